// File: rtl/jt6295_slot_sched.sv
// Sample/slot time-base and ADPCM ROM arbiter for the JT6295 voice datapath.
// Optional overrun counter is enabled by defining JT6295_OVRCNT_EN.
module jt6295_slot_sched #(
    parameter int DIV_HI = 165,
    parameter int DIV_LO = 132,
    parameter int AW     = 18
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cen_base,
    input  logic          ss,
    input  logic [3:0]    ch_active,
    input  logic [AW-1:0] addr_in,
    input  logic          rom_ok,
    input  logic [7:0]    rom_data,
    output logic          cen,
    output logic          cen4,
    output logic [1:0]    ch,
    output logic          rom_cs,
    output logic [AW-1:0] rom_addr,
    output logic          data_valid,
    output logic [7:0]    dout,
    output logic [3:0]    overrun,
    output logic [7:0]    ovr_cnt
);

    typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, DONE = 2'd2} state_t;

    localparam logic [7:0] HI_B1   = 8'((DIV_HI * 1) / 4);
    localparam logic [7:0] HI_B2   = 8'((DIV_HI * 2) / 4);
    localparam logic [7:0] HI_B3   = 8'((DIV_HI * 3) / 4);
    localparam logic [7:0] HI_LAST = 8'(DIV_HI - 1);
    localparam logic [7:0] LO_B1   = 8'((DIV_LO * 1) / 4);
    localparam logic [7:0] LO_B2   = 8'((DIV_LO * 2) / 4);
    localparam logic [7:0] LO_B3   = 8'((DIV_LO * 3) / 4);
    localparam logic [7:0] LO_LAST = 8'(DIV_LO - 1);

    state_t        state_q, state_d;
    logic [7:0]    cnt_q, cnt_d;
    logic          div_sel_q, div_sel_d;
    logic          first_q, first_d;
    logic          cen_q, cen_d, cen4_q, cen4_d;
    logic [1:0]    ch_q, ch_d;
    logic          rom_cs_q, rom_cs_d;
    logic [AW-1:0] rom_addr_q, rom_addr_d;
    logic          data_valid_q, data_valid_d;
    logic [7:0]    dout_q, dout_d;
    logic [3:0]    overrun_q, overrun_d;
    logic          slot_start_s, abort_s;
    logic [1:0]    slot_k_s;
    logic [7:0]    b1_s, b2_s, b3_s, last_s;

    // Divider and slot boundary detection; ss only takes effect at wrap
    always_comb begin
        b1_s         = div_sel_q ? LO_B1   : HI_B1;
        b2_s         = div_sel_q ? LO_B2   : HI_B2;
        b3_s         = div_sel_q ? LO_B3   : HI_B3;
        last_s       = div_sel_q ? LO_LAST : HI_LAST;
        cnt_d        = cnt_q;
        div_sel_d    = div_sel_q;
        slot_k_s     = 2'd0;
        slot_start_s = 1'b0;
        if (cnt_q == 8'd0) begin
            slot_start_s = cen_base;
        end else if (cnt_q == b1_s) begin
            slot_start_s = cen_base;
            slot_k_s     = 2'd1;
        end else if (cnt_q == b2_s) begin
            slot_start_s = cen_base;
            slot_k_s     = 2'd2;
        end else if (cnt_q == b3_s) begin
            slot_start_s = cen_base;
            slot_k_s     = 2'd3;
        end else begin
            slot_start_s = 1'b0;
        end
        if (cen_base) begin
            if (cnt_q == last_s) begin
                cnt_d     = 8'd0;
                div_sel_d = ss;
            end else begin
                cnt_d = cnt_q + 8'd1;
            end
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Slot strobes, ROM arbitration FSM and overrun tracking
    always_comb begin
        state_d      = state_q;
        first_d      = first_q;
        data_valid_d = 1'b0;
        dout_d       = dout_q;
        overrun_d    = overrun_q;
        abort_s      = 1'b0;
        cen_d        = slot_start_s && (slot_k_s == 2'd0);
        cen4_d       = slot_start_s;
        ch_d         = slot_start_s ? slot_k_s : ch_q;
        rom_addr_d   = slot_start_s ? addr_in : rom_addr_q;
        case (state_q)
            REQ: begin
                if (slot_start_s) begin
                    // abort beats a coincident rom_ok: data is dropped
                    abort_s            = 1'b1;
                    overrun_d[ch_q]    = 1'b1;
                    state_d            = IDLE;
                end else if (first_q) begin
                    first_d = 1'b0;
                end else if (rom_ok) begin
                    data_valid_d = 1'b1;
                    dout_d       = rom_data;
                    state_d      = DONE;
                end else begin
                    state_d = REQ;
                end
            end
            IDLE:    state_d = IDLE;
            DONE:    state_d = DONE;
            default: state_d = IDLE;
        endcase
        if (slot_start_s) begin
            state_d = ch_active[slot_k_s] ? REQ : IDLE;
            first_d = 1'b1;
        end else begin
            first_d = first_d;
        end
        rom_cs_d = (state_d == REQ);
    end

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= 8'd0;
            div_sel_q    <= 1'b0;
            first_q      <= 1'b0;
            cen_q        <= 1'b0;
            cen4_q       <= 1'b0;
            ch_q         <= 2'd0;
            rom_cs_q     <= 1'b0;
            rom_addr_q   <= '0;
            data_valid_q <= 1'b0;
            dout_q       <= 8'd0;
            overrun_q    <= 4'd0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            div_sel_q    <= div_sel_d;
            first_q      <= first_d;
            cen_q        <= cen_d;
            cen4_q       <= cen4_d;
            ch_q         <= ch_d;
            rom_cs_q     <= rom_cs_d;
            rom_addr_q   <= rom_addr_d;
            data_valid_q <= data_valid_d;
            dout_q       <= dout_d;
            overrun_q    <= overrun_d;
        end
    end

`ifdef JT6295_OVRCNT_EN
    logic [7:0] ovr_cnt_q, ovr_cnt_d;

    // Saturating abort counter
    always_comb begin
        if (abort_s && (ovr_cnt_q != 8'hFF)) begin
            ovr_cnt_d = ovr_cnt_q + 8'd1;
        end else begin
            ovr_cnt_d = ovr_cnt_q;
        end
    end

    // Abort counter register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovr_cnt_q <= 8'd0;
        end else begin
            ovr_cnt_q <= ovr_cnt_d;
        end
    end

    assign ovr_cnt = ovr_cnt_q;
`else
    logic unused_abort_s;
    assign unused_abort_s = abort_s;
    assign ovr_cnt        = 8'd0;
`endif

    assign cen        = cen_q;
    assign cen4       = cen4_q;
    assign ch         = ch_q;
    assign rom_cs     = rom_cs_q;
    assign rom_addr   = rom_addr_q;
    assign data_valid = data_valid_q;
    assign dout       = dout_q;
    assign overrun    = overrun_q;

endmodule
